// File: rtl/seven_seg_pkg.sv
// Shared types, glyph constants and polarity helpers for the seven-segment scan controller.
// Optional PWM dimming in the top level is enabled with `define SEVENSEG_PWM_EN.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } scan_state_t;

    localparam int MAX_DIGITS = 16;
    localparam int MAX_SEG_W  = 8;

    // Segment order is {a,b,c,d,e,f,g} with a in the MSB; 1 = lit.
    localparam logic [6:0] GLYPH_0     = 7'b1111110;
    localparam logic [6:0] GLYPH_1     = 7'b0110000;
    localparam logic [6:0] GLYPH_2     = 7'b1101101;
    localparam logic [6:0] GLYPH_3     = 7'b1111001;
    localparam logic [6:0] GLYPH_4     = 7'b0110011;
    localparam logic [6:0] GLYPH_5     = 7'b1011011;
    localparam logic [6:0] GLYPH_6     = 7'b1011111;
    localparam logic [6:0] GLYPH_7     = 7'b1110000;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1111011;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Level that leaves every common switched off, for the widest supported bank.
    function automatic logic [MAX_DIGITS-1:0] comInactive(input logic comActiveLow);
        return comActiveLow ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

    function automatic logic [MAX_SEG_W-1:0] segUnlit(input logic segActiveLow);
        return segActiveLow ? {MAX_SEG_W{1'b1}} : {MAX_SEG_W{1'b0}};
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot counter and digit index for the scan controller; provides next-cycle values
// so the top level can register its outputs against the same cycle they describe.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int PRESCALE = 1000,
    localparam int CNT_W = $clog2(PRESCALE),
    localparam int DIG_W = $clog2(N_DIGITS)
) (
    input  logic             iCLK,
    input  logic             nRST,
    input  logic             iEN,
    input  logic             iActive,
    output logic [CNT_W-1:0] oCntNext,
    output logic [DIG_W-1:0] oDigit,
    output logic [DIG_W-1:0] oDigitNext,
    output logic             oFrameStart,
    output logic             oFrameDoneNext
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             slotEnd;

    assign running = iEN && iActive;
    assign slotEnd = running && (cnt == CNT_LAST);

    // A digit-0 slot begins either when leaving idle or when the last digit's slot wraps.
    assign oFrameStart    = iEN && (!iActive || (slotEnd && (oDigit == DIG_LAST)));
    assign oFrameDoneNext = iEN && (oCntNext == CNT_LAST) && (oDigitNext == DIG_LAST);

    always_comb begin
        oCntNext   = '0;
        oDigitNext = '0;
        if (running) begin
            if (slotEnd) begin
                oCntNext   = '0;
                oDigitNext = (oDigit == DIG_LAST) ? '0 : oDigit + DIG_W'(1);
            end else begin
                oCntNext   = cnt + CNT_W'(1);
                oDigitNext = oDigit;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (nRST) begin
            cnt    <= '0;
            oDigit <= '0;
        end else begin
            cnt    <= oCntNext;
            oDigit <= oDigitNext;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment driver with frame-coherent snapshots,
// dead time, per-digit blanking; `define SEVENSEG_PWM_EN adds 16-step brightness PWM.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SEG_W          = 7,
    parameter int PRESCALE       = 1000,
    parameter int DEAD_CYC       = 2,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                        iCLK,
    input  logic                        nRST,
    input  logic                        iEN,
    input  logic [N_DIGITS*SEG_W-1:0]   iSEG,
    input  logic [N_DIGITS-1:0]         iBLANK,
    input  logic [3:0]                  iBRIGHT,
    output logic [N_DIGITS-1:0]         oS_COM,
    output logic [SEG_W-1:0]            oS_ENS,
    output logic [$clog2(N_DIGITS)-1:0] oDIGIT,
    output logic                        oFRAME_DONE
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int DIG_W = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]      DEAD_L    = CNT_W'(DEAD_CYC);
    localparam logic [MAX_DIGITS-1:0] COM_OFF_W = comInactive(COM_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0]   COM_OFF   = COM_OFF_W[N_DIGITS-1:0];
    localparam logic [MAX_SEG_W-1:0]  SEG_OFF_W = segUnlit(SEG_ACTIVE_LOW);
    localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_OFF_W[SEG_W-1:0];
    localparam logic [N_DIGITS-1:0]   ONE_HOT0  = {{(N_DIGITS-1){1'b0}}, 1'b1};

    scan_state_t stateQ;

    logic [CNT_W-1:0] cntNext;
    logic [DIG_W-1:0] digitNext;
    logic             frameStart;
    logic             frameDoneNext;

    logic [N_DIGITS*SEG_W-1:0] segSh, segShNext;
    logic [N_DIGITS-1:0]       blankSh, blankShNext;
    logic                      slotOnNext;
    logic                      litNext;
    logic [N_DIGITS-1:0]       comNext;
    logic [SEG_W-1:0]          ensNext;

`ifdef SEVENSEG_PWM_EN
    logic [3:0] brightSh, brightShNext;
    logic [3:0] phase, phaseNext;
`else
    logic unusedBright;
    assign unusedBright = ^iBRIGHT;
`endif

    seven_seg_slot_timer #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE)
    ) uTimer (
        .iCLK           (iCLK),
        .nRST           (nRST),
        .iEN            (iEN),
        .iActive        (stateQ != IDLE),
        .oCntNext       (cntNext),
        .oDigit         (oDIGIT),
        .oDigitNext     (digitNext),
        .oFrameStart    (frameStart),
        .oFrameDoneNext (frameDoneNext)
    );

    // Outputs are computed from next-cycle values so the registered pins line up with cnt/oDIGIT.
    always_comb begin
        segShNext   = frameStart ? iSEG   : segSh;
        blankShNext = frameStart ? iBLANK : blankSh;
        slotOnNext  = (cntNext >= DEAD_L);
        litNext     = iEN && slotOnNext && !blankShNext[digitNext];
`ifdef SEVENSEG_PWM_EN
        brightShNext = frameStart ? iBRIGHT : brightSh;
        phaseNext    = '0;
        if (iEN && slotOnNext && (cntNext != DEAD_L))
            phaseNext = phase + 4'd1;
        litNext = litNext && (phaseNext <= brightShNext);
`endif
        comNext = COM_OFF;
        ensNext = SEG_OFF;
        if (litNext) begin
            comNext = COM_OFF ^ (ONE_HOT0 << digitNext);
            ensNext = segShNext[digitNext*SEG_W +: SEG_W] ^ SEG_OFF;
        end
    end

    always_ff @(posedge iCLK) begin
        if (nRST) begin
            stateQ      <= IDLE;
            segSh       <= '0;
            blankSh     <= '0;
            oS_COM      <= COM_OFF;
            oS_ENS      <= SEG_OFF;
            oFRAME_DONE <= 1'b0;
`ifdef SEVENSEG_PWM_EN
            brightSh    <= '0;
            phase       <= '0;
`endif
        end else begin
            case (stateQ)
                IDLE: begin
                    if (iEN)
                        stateQ <= slotOnNext ? ON : DEAD;
                end
                DEAD, ON: begin
                    if (!iEN)
                        stateQ <= IDLE;
                    else
                        stateQ <= slotOnNext ? ON : DEAD;
                end
                default: stateQ <= IDLE;
            endcase
            segSh       <= segShNext;
            blankSh     <= blankShNext;
            oS_COM      <= comNext;
            oS_ENS      <= ensNext;
            oFRAME_DONE <= frameDoneNext;
`ifdef SEVENSEG_PWM_EN
            brightSh    <= brightShNext;
            phase       <= phaseNext;
`endif
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: 4 digits, dead time 2, slot 8 cycles
// (34 when SEVENSEG_PWM_EN is defined), checked every cycle against a frame-time model.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SW = 7;
    localparam int D  = 2;
`ifdef SEVENSEG_PWM_EN
    localparam int P  = 34;
`else
    localparam int P  = 8;
`endif
    localparam int FRAME = N * P;

    logic          iCLK = 1'b0;
    logic          nRST;
    logic          iEN;
    logic [N*SW-1:0] iSEG;
    logic [N-1:0]  iBLANK;
    logic [3:0]    iBRIGHT;
    logic [N-1:0]  oS_COM;
    logic [SW-1:0] oS_ENS;
    logic [1:0]    oDIGIT;
    logic          oFRAME_DONE;

    int nChecks = 0;
    int nFail   = 0;
    bit chkOn   = 1'b0;

    seven_seg_scan_ctrl #(
        .N_DIGITS       (N),
        .SEG_W          (SW),
        .PRESCALE       (P),
        .DEAD_CYC       (D),
        .COM_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .iCLK        (iCLK),
        .nRST        (nRST),
        .iEN         (iEN),
        .iSEG        (iSEG),
        .iBLANK      (iBLANK),
        .iBRIGHT     (iBRIGHT),
        .oS_COM      (oS_COM),
        .oS_ENS      (oS_ENS),
        .oDIGIT      (oDIGIT),
        .oFRAME_DONE (oFRAME_DONE)
    );

    // ---------------- clock ----------------
    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [6:0] glyphOf(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [N*SW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
        return {glyphOf(d3), glyphOf(d2), glyphOf(d1), glyphOf(d0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time since scanning started decides slot and digit; shadows refresh every FRAME cycles.
    bit              mRun = 1'b0;
    int              mT   = 0;
    logic [N*SW-1:0] mSeg;
    logic [N-1:0]    mBlank;
    logic [3:0]      mBright;
    logic [N-1:0]    eCom;
    logic [SW-1:0]   eEns;
    int              eDig;
    logic            eFd;
    int              mCnt;
    int              mDig;
    bit              mLit;

    always @(posedge iCLK) begin
        if (nRST) begin
            mRun = 1'b0; mT = 0;
            mSeg = '0; mBlank = '0; mBright = '0;
        end else if (!iEN) begin
            mRun = 1'b0; mT = 0;
        end else begin
            if (mRun) mT++;
            else begin mRun = 1'b1; mT = 0; end
            if (mT % FRAME == 0) begin
                mSeg = iSEG; mBlank = iBLANK; mBright = iBRIGHT;
            end
        end
        eCom = '1; eEns = '0; eDig = 0; eFd = 1'b0;
        if (mRun) begin
            mCnt = mT % P;
            mDig = (mT / P) % N;
            eDig = mDig;
            eFd  = (mCnt == P - 1) && (mDig == N - 1);
            mLit = (mCnt >= D) && !mBlank[mDig];
`ifdef SEVENSEG_PWM_EN
            mLit = mLit && (((mCnt - D) % 16) <= int'(mBright));
`endif
            if (mLit) begin
                eCom[mDig] = 1'b0;
                eEns = mSeg[mDig*SW +: SW];
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge iCLK) begin
        if (chkOn) begin
            check("model_com", oS_COM, eCom);
            check("model_ens", oS_ENS, eEns);
            check("model_digit", oDIGIT, eDig);
            check("model_frame_done", oFRAME_DONE, eFd);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic waitFrameDone(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 2*FRAME + 4 && !found; i++) begin
            @(negedge iCLK);
            if (oFRAME_DONE) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    task automatic waitDigitLit(input string name, input int dig);
        bit found = 1'b0;
        logic [N-1:0] want;
        want = '1;
        want[dig] = 1'b0;
        for (int i = 0; i < 2*FRAME + 4 && !found; i++) begin
            @(negedge iCLK);
            if (oS_COM == want) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    task automatic waitDigit(input string name, input int dig);
        bit found = 1'b0;
        for (int i = 0; i < 2*FRAME + 4 && !found; i++) begin
            @(negedge iCLK);
            if (oDIGIT == dig[1:0]) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int litCnt;
    int fdCnt;

    initial begin
        nRST = 1'b1; iEN = 1'b0; iSEG = '0; iBLANK = '0; iBRIGHT = 4'd3;
        repeat (3) @(negedge iCLK);
        chkOn = 1'b1;
        check("rst_com", oS_COM, 4'b1111);
        check("rst_ens", oS_ENS, 7'b0000000);
        check("rst_digit", oDIGIT, 2'd0);
        check("rst_frame_done", oFRAME_DONE, 1'b0);

        // Basic scan of digits 1,2,3,4 with literal pins on one full frame.
        nRST = 1'b0; iEN = 1'b1; iSEG = pack(1, 2, 3, 4);
        @(negedge iCLK);
        check("start_dead_com", oS_COM, 4'b1111);
        waitFrameDone("wait_first_frame");
        litCnt = 0; fdCnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge iCLK);
            if (oS_COM != 4'b1111) litCnt++;
            if (oFRAME_DONE) fdCnt++;
            if (i == 0)       check("slot0_dead_com", oS_COM, 4'b1111);
            if (i == D)       begin check("d0_com", oS_COM, 4'b1110); check("d0_ens", oS_ENS, 7'b0110000); end
            if (i == P + D)   begin check("d1_com", oS_COM, 4'b1101); check("d1_ens", oS_ENS, 7'b1101101); end
            if (i == 2*P + D) begin check("d2_com", oS_COM, 4'b1011); check("d2_ens", oS_ENS, 7'b1111001); end
            if (i == 3*P + D) begin check("d3_com", oS_COM, 4'b0111); check("d3_ens", oS_ENS, 7'b0110011); end
`ifdef SEVENSEG_PWM_EN
            if (i == D + 4)   check("pwm_phase4_dark", oS_COM, 4'b1111);
            if (i == D + 16)  check("pwm_phase16_lit", oS_COM, 4'b1110);
`else
            if (i == D + 4)   check("on_mid_slot_com", oS_COM, 4'b1110);
`endif
            if (i == FRAME - 1) check("frame_done_last", oFRAME_DONE, 1'b1);
        end
        check("frame_done_count", fdCnt, 1);
`ifdef SEVENSEG_PWM_EN
        check("lit_cycles_per_frame", litCnt, 32);
`else
        check("lit_cycles_per_frame", litCnt, 24);
`endif

        // Mid-frame change of digit 0 shows only from the next frame.
        repeat (10) @(negedge iCLK);
        iSEG = pack(8, 2, 3, 4);
        waitFrameDone("wait_after_change");
        repeat (D + 1) @(negedge iCLK);
        check("new_frame_d0_ens", oS_ENS, 7'b1111111);

        // Blank digit 2.
        iBLANK = 4'b0100;
        waitFrameDone("wait_blank_arm");
        waitFrameDone("wait_blank_frame");
        repeat (2*P + D + 1) @(negedge iCLK);
        check("blank_d2_com", oS_COM, 4'b1111);
        check("blank_d2_ens", oS_ENS, 7'b0000000);
        iBLANK = 4'b0000;

        // Abort during digit 2 ON, then restart with a fresh snapshot.
        waitFrameDone("wait_unblank");
        waitDigitLit("wait_d2_on", 2);
        iEN = 1'b0;
        @(negedge iCLK);
        check("abort_com", oS_COM, 4'b1111);
        check("abort_digit", oDIGIT, 2'd0);
        repeat (3) @(negedge iCLK);
        iSEG = pack(5, 6, 7, 9);
        iEN = 1'b1;
        @(negedge iCLK);
        check("restart_dead_com", oS_COM, 4'b1111);
        repeat (D) @(negedge iCLK);
        check("restart_d0_com", oS_COM, 4'b1110);
        check("restart_d0_ens", oS_ENS, 7'b1011011);

        // Reset one cycle before the frame-done cycle of digit 3.
        waitDigit("wait_d3", 3);
        repeat (P - 2) @(negedge iCLK);
        nRST = 1'b1;
        @(negedge iCLK);
        check("midrst_digit", oDIGIT, 2'd0);
        check("midrst_frame_done", oFRAME_DONE, 1'b0);
        check("midrst_com", oS_COM, 4'b1111);
        nRST = 1'b0;

        // Randomised traffic: data churn, enable drops and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge iCLK);
            if ($urandom_range(0, 7) == 0)   iSEG    = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)  iBLANK  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)  iBRIGHT = 4'($urandom_range(0, 15));
            if (iEN && $urandom_range(0, 299) == 0) iEN = 1'b0;
            else if (!iEN && $urandom_range(0, 3) == 0) iEN = 1'b1;
            nRST = ($urandom_range(0, 599) == 0);
        end
        nRST = 1'b0;
        repeat (2) @(negedge iCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Parametrised time-multiplexed driver for an N-digit common-cathode/anode 7-segment bank. It replaces the fixed 8-digit, one-clock-per-digit scanner with a configurable digit count, per-digit slot length and anti-ghosting dead time. It also adds frame-coherent input snapshotting, per-digit blanking and an enable control. It sits between the BCD/7-seg decoders and the board's segment/common pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16)
SEG_W, 7, segment bits per digit (7, or 8 with dp)
PRESCALE, 1000, iCLK cycles per digit slot (>= 2)
DEAD_CYC, 2, cycles at slot start with all commons inactive (0..PRESCALE-1)
COM_ACTIVE_LOW, 1, 1: selected common driven 0; 0: driven 1
SEG_ACTIVE_LOW, 0, 1: oS_ENS inverted (lit segment = 0)

Ports:
iCLK  in  1  clock
nRST  in  1  synchronous, active-high reset
iEN  in  1  scan enable
iSEG  in  N_DIGITS*SEG_W  segment patterns; digit k at [k*SEG_W +: SEG_W], 1 = lit
iBLANK  in  N_DIGITS  1 = digit k dark for whole slot
iBRIGHT  in  4  brightness; used only with the optional feature
oS_COM  out  N_DIGITS  digit commons
oS_ENS  out  SEG_W  segment drive
oDIGIT  out  $clog2(N_DIGITS)  index of current slot
oFRAME_DONE  out  1  one-cycle pulse on last cycle of digit N_DIGITS-1 slot

Behaviour:
- Reset is nRST, synchronous, active-high, with clock iCLK. All outputs are registered.
- Reset values: state IDLE, cnt 0, oDIGIT 0, oS_COM all inactive (all 1s when COM_ACTIVE_LOW), oS_ENS all unlit, oFRAME_DONE 0, shadow registers 0.
- States are IDLE, DEAD and ON. Slot counter cnt runs 0..PRESCALE-1.
- IDLE: outputs are inactive and cnt and oDIGIT are held at 0.
  - If iEN=1, the next edge enters DEAD (ON if DEAD_CYC=0), with digit 0 and cnt 0.
  - The snapshot is taken on that same edge.
- Snapshot: iSEG, iBLANK and iBRIGHT are copied into shadow registers on every edge that starts a digit-0 slot. The display uses shadows only, so no mid-frame tearing occurs.
- DEAD (cnt < DEAD_CYC): all commons are inactive and oS_ENS is unlit.
- ON (cnt >= DEAD_CYC):
  - Common oDIGIT is active and the others inactive.
  - oS_ENS = shadow pattern of oDIGIT, XOR all-ones if SEG_ACTIVE_LOW.
  - If shadow blank bit is set, output as in DEAD.
- Slot end (cnt == PRESCALE-1):
  - Next edge sets cnt to 0 and oDIGIT to oDIGIT+1, wrapping N_DIGITS-1 to 0.
  - The state becomes DEAD, or ON if DEAD_CYC=0.
- oFRAME_DONE is 1 exactly in the cycle where cnt == PRESCALE-1 and oDIGIT == N_DIGITS-1.
- Frame period is N_DIGITS*PRESCALE cycles.
- iEN deasserted in any state: next edge goes to IDLE. This is an immediate abort with no slot completion.
- Reset mid-slot: reset values are restored on the next edge; no partial frame continues.
- Changes to iSEG mid-frame take effect from the next frame start only.
- Only one common is ever active, and never during DEAD.

Optional Feature:
SEVENSEG_PWM_EN
- With the macro: a 4-bit phase counter is cleared at each ON entry and increments every ON cycle, wrapping at 16.
  - The common and segments are active only while phase <= shadow iBRIGHT; otherwise outputs are as in DEAD.
  - iBRIGHT=15 gives full on; iBRIGHT=0 gives 1/16 duty.
- Without the macro: iBRIGHT is ignored and no phase counter exists. The ON window is fully lit.

Decomposition:
- Shared package seven_seg_pkg holds:
  - state enum (IDLE, DEAD, ON)
  - 7-bit glyph constants for 0-9 and blank
  - COM_INACTIVE/SEG_UNLIT helper functions, parameterised by the polarity flags
- One sub-module, seven_seg_slot_timer:
  - contains cnt, oDIGIT wrap, the slot_end strobe and the frame_start strobe
  - the top level holds the FSM, shadows and output decode

Test Plan:
1. N=4, PRESCALE=8, DEAD_CYC=2, iEN=1 after reset, iSEG=digits {1,2,3,4}.
   - Each slot shows 2 cycles all-inactive, then 6 cycles of COM 1110/1101/1011/0111 with patterns 0110000/1101101/1111001/0110011.
   - oFRAME_DONE pulses every 32 cycles.
2. Same setup, change iSEG digit0 to 8 at cycle 10 of a frame.
   - Digit 0 keeps showing 1 until the next frame start, then 1111111.
3. iBLANK=0100 (digit 2 blanked).
   - Slot 2 has COM all 1s and ENS 0 for all 8 cycles; other digits are unaffected.
4. iEN dropped during digit 2 ON.
   - Next cycle: IDLE, outputs inactive.
   - On re-enable, scan restarts at digit 0 with DEAD, and a fresh snapshot is taken.
5. nRST pulsed mid-slot of digit 3.
   - Next edge gives reset values, oDIGIT=0 and no oFRAME_DONE.
6. With SEVENSEG_PWM_EN, PRESCALE=34, DEAD_CYC=2, iBRIGHT=3.
   - Each 32-cycle ON window shows the common active for phases 0-3 and 16-19 (8 of 32 cycles).
